// File: rtl/uart_feedback_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling; decodes tagged
// feedback bytes into player_ready / target_reached / item_code fields.
module uart_feedback_rx #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter logic [1:0]  FB_TAG     = 2'b00
) (
   input  logic       uart_clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       fb_valid,
   output logic       player_ready,
   output logic       target_reached,
   output logic [3:0] item_code
);

   localparam int unsigned TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t        r_state, w_next;
   logic          r_rx_meta, r_rx_s;
   logic [TW-1:0] r_tick;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_dv, r_ferr, r_fbv;
   logic          r_pr, r_tr;
   logic [3:0]    r_item;
   logic          w_tick_clr, w_shift_en, w_load, w_ferr;

   always_ff @(posedge uart_clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= IDLE;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_state   <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_tick_clr = 1'b0;
      w_shift_en = 1'b0;
      w_load     = 1'b0;
      w_ferr     = 1'b0;
      case (r_state)
         IDLE: begin
            w_tick_clr = 1'b1;
            if (!r_rx_s) w_next = START;
         end
         START: begin
            if (r_tick == TICK_MID) begin
               w_tick_clr = 1'b1;
               w_next     = r_rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (r_tick == TICK_MAX) begin
               w_shift_en = 1'b1;
               if (r_bit_idx == 3'd7) w_next = STOP;
            end
         end
         STOP: begin
            if (r_tick == TICK_MAX) begin
               w_tick_clr = 1'b1;
               if (r_rx_s) begin
                  w_load = 1'b1;
                  w_next = IDLE;
               end else begin
                  w_ferr = 1'b1;
                  w_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            w_tick_clr = 1'b1;
            if (r_rx_s) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // The shift register receives LSB first, so the completed byte sits in r_shift in order.
   always_ff @(posedge uart_clk) begin
      if (rst) begin
         r_tick    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_dv      <= 1'b0;
         r_ferr    <= 1'b0;
         r_fbv     <= 1'b0;
         r_pr      <= 1'b0;
         r_tr      <= 1'b0;
         r_item    <= '0;
      end else begin
         r_dv   <= w_load;
         r_ferr <= w_ferr;
         r_fbv  <= w_load && (r_shift[1:0] == FB_TAG);
         if (w_tick_clr || r_tick == TICK_MAX) r_tick <= '0;
         else                                  r_tick <= r_tick + 1'b1;
         if (r_state == IDLE) r_bit_idx <= '0;
         else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + 1'b1;
            r_shift   <= {r_rx_s, r_shift[7:1]};
         end
         if (w_load) begin
            r_data <= r_shift;
            if (r_shift[1:0] == FB_TAG) begin
               r_pr   <= r_shift[2];
               r_tr   <= r_shift[3];
               r_item <= r_shift[7:4];
            end
         end
      end
   end

   assign data           = r_data;
   assign data_valid     = r_dv;
   assign frame_err      = r_ferr;
   assign fb_valid       = r_fbv;
   assign player_ready   = r_pr;
   assign target_reached = r_tr;
   assign item_code      = r_item;

endmodule

// File: tb/tb_uart_feedback_rx.sv
// Directed bench for uart_feedback_rx: expected bytes queued on send,
// compared against captured data_valid events.
module tb_uart_feedback_rx;

   localparam int unsigned OS = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       fb;
      logic       pr;
      logic       tr;
      logic [3:0] item;
      int         cyc;
   } ev_t;

   logic       uart_clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       data_valid, frame_err, fb_valid;
   logic       player_ready, target_reached;
   logic [3:0] item_code;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  cyc = 0;
   int  dv_cnt = 0, ferr_cnt = 0, viol_cnt = 0;
   logic prev_dv = 1'b0, prev_fe = 1'b0;
   int  n_vec = 0, n_err = 0;
   logic       m_pr = 1'b0, m_tr = 1'b0;
   logic [3:0] m_item = 4'h0;

   uart_feedback_rx #(.OVERSAMPLE(OS), .FB_TAG(2'b00)) dut (
      .uart_clk(uart_clk), .rst(rst), .rx(rx),
      .data(data), .data_valid(data_valid), .frame_err(frame_err),
      .fb_valid(fb_valid), .player_ready(player_ready),
      .target_reached(target_reached), .item_code(item_code)
   );

   always #5 uart_clk = ~uart_clk;
   always @(posedge uart_clk) cyc <= cyc + 1;

   // Capture outputs mid-cycle; multi-cycle or overlapping pulses count as violations.
   always @(negedge uart_clk) begin
      if (data_valid) begin
         obs_q.push_back('{data, fb_valid, player_ready, target_reached, item_code, cyc});
         dv_cnt <= dv_cnt + 1;
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if ((data_valid && frame_err) || (data_valid && prev_dv) || (frame_err && prev_fe)
          || (fb_valid && !data_valid))
         viol_cnt <= viol_cnt + 1;
      prev_dv <= data_valid;
      prev_fe <= frame_err;
   end

   task automatic chk(input string tag, input int obs, input int expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(posedge uart_clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] b, input int start_cyc);
      if (b[1:0] == 2'b00) begin
         m_pr = b[2]; m_tr = b[3]; m_item = b[7:4];
      end
      exp_q.push_back('{b, (b[1:0] == 2'b00), m_pr, m_tr, m_item, start_cyc + 155});
   endtask

   task automatic send(input logic [7:0] b, input logic stop_bit, input logic expect_ok);
      logic [7:0] v;
      v = b;
      if (expect_ok) push_exp(b, cyc);
      rx = 1'b0; clk_n(OS);
      for (int i = 0; i < 8; i++) begin
         rx = v[i]; clk_n(OS);
      end
      rx = stop_bit; clk_n(OS);
   endtask

   task automatic drain(input string tag);
      ev_t e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            chk({tag, "_missing_dv"}, 0, 1);
         end else begin
            o = obs_q.pop_front();
            chk({tag, "_data"}, o.d, e.d);
            chk({tag, "_fb_valid"}, o.fb, e.fb);
            chk({tag, "_fields"}, {o.pr, o.tr, o.item}, {e.pr, e.tr, e.item});
            chk({tag, "_latency"}, o.cyc, e.cyc);
         end
      end
      chk({tag, "_extra_dv"}, obs_q.size(), 0);
   endtask

   initial begin
      int dv0, fe0, t0;
      ev_t o;
      clk_n(3);
      rst = 1'b0;
      chk("reset_outputs", {data, data_valid, frame_err, fb_valid, player_ready,
                            target_reached, item_code}, 0);
      clk_n(5);

      send(8'hA4, 1'b1, 1'b1); clk_n(4);
      chk("A4_item_code", item_code, 4'hA);
      chk("A4_pr_tr", {player_ready, target_reached}, 2'b10);
      drain("A4");

      send(8'h05, 1'b1, 1'b1); clk_n(4);
      chk("05_fields_held", {player_ready, target_reached, item_code}, {2'b10, 4'hA});
      drain("05");

      dv0 = dv_cnt; fe0 = ferr_cnt;
      rx = 1'b0; clk_n(4); rx = 1'b1; clk_n(40);
      chk("glitch_no_dv", dv_cnt, dv0);
      chk("glitch_no_ferr", ferr_cnt, fe0);

      send(8'h55, 1'b0, 1'b0);
      clk_n(40 * OS);
      rx = 1'b1; clk_n(3 * OS);
      chk("break_one_ferr", ferr_cnt, fe0 + 1);
      chk("break_data_held", data, 8'h05);
      chk("break_no_dv", dv_cnt, dv0);
      send(8'h3C, 1'b1, 1'b1); clk_n(4);
      drain("3C");

      dv0 = dv_cnt;
      send(8'h10, 1'b1, 1'b1);
      send(8'hF8, 1'b1, 1'b1);
      clk_n(4);
      chk("b2b_two_dv", dv_cnt, dv0 + 2);
      if (obs_q.size() >= 2) begin
         o = obs_q[0];
         t0 = o.cyc;
         o = obs_q[1];
         chk("b2b_spacing", o.cyc - t0, 160);
      end else chk("b2b_spacing_present", obs_q.size(), 2);
      drain("b2b");

      dv0 = dv_cnt; fe0 = ferr_cnt;
      rx = 1'b0; clk_n(OS);
      for (int i = 0; i < 4; i++) begin rx = 1'b1; clk_n(OS); end
      clk_n(OS / 2);
      rst = 1'b1; clk_n(3);
      chk("rst_mid_outputs", {data, data_valid, frame_err, fb_valid, player_ready,
                              target_reached, item_code}, 0);
      m_pr = 1'b0; m_tr = 1'b0; m_item = 4'h0;
      rst = 1'b0;
      clk_n(OS / 2 - 3 + 4 * OS);
      clk_n(4 * OS);
      chk("rst_no_dv", dv_cnt, dv0);
      chk("rst_no_ferr", ferr_cnt, fe0);
      send(8'h2C, 1'b1, 1'b1); clk_n(4);
      drain("2C");

      chk("pulse_violations", viol_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_feedback_rx.md
UART_FEEDBACK_RX -- requirements
Module: uart_feedback_rx

Interface
REQ-001 The module SHALL have parameter OVERSAMPLE, default 16, giving uart_clk cycles per UART bit period.
REQ-002 The module SHALL have parameter FB_TAG, default 2'b00, giving the channel tag of feedback bytes.
REQ-003 The module SHALL have port uart_clk, input, 1 bit: the single clock, OVERSAMPLE x baud rate.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port rx, input, 1 bit: asynchronous serial line from the game client, idle high.
REQ-006 The module SHALL have port data, output, 8 bits: last correctly framed byte received.
REQ-007 The module SHALL have port data_valid, output, 1 bit: single-cycle pulse when data updates.
REQ-008 The module SHALL have port frame_err, output, 1 bit: single-cycle pulse when the stop bit samples low.
REQ-009 The module SHALL have port fb_valid, output, 1 bit: single-cycle pulse coincident with data_valid when data[1:0] == FB_TAG.
REQ-010 The module SHALL have port player_ready, output, 1 bit: byte bit 2, latched on fb_valid.
REQ-011 The module SHALL have port target_reached, output, 1 bit: byte bit 3, latched on fb_valid.
REQ-012 The module SHALL have port item_code, output, 4 bits: byte bits 7:4, latched on fb_valid.

Function
REQ-013 The module SHALL pass rx through a two-flop synchronizer (rx_s) and use only rx_s internally.
REQ-014 The line format SHALL be 8N1: start bit 0, eight data bits LSB first, stop bit 1, no parity.
REQ-015 The module SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 In IDLE, the module SHALL enter START and clear the tick counter when rx_s == 0.
REQ-017 In START, at tick OVERSAMPLE/2-1 (mid-bit), the module SHALL reset the tick counter and enter DATA if rx_s == 0; otherwise it SHALL return to IDLE (glitch reject) with no outputs.
REQ-018 In DATA, the module SHALL sample rx_s every OVERSAMPLE ticks into bit index 0..7, LSB first; after bit 7 it SHALL enter STOP.
REQ-019 In STOP, at the mid-bit sample of the stop bit, if rx_s == 1 the module SHALL load data, pulse data_valid on the next cycle and enter IDLE.
REQ-020 In STOP, if the stop-bit sample is 0, the module SHALL leave data unchanged, pulse frame_err on the next cycle and enter WAIT_HIGH.
REQ-021 The module SHALL remain in WAIT_HIGH until rx_s == 1, then enter IDLE; a break condition SHALL produce only one frame_err.
REQ-022 The tick counter SHALL be ceil(log2(OVERSAMPLE)) bits wide and wrap to 0 at OVERSAMPLE-1.
REQ-023 The bit index SHALL be 3 bits wide and SHALL wrap to 0 on entry to STOP.
REQ-024 data_valid, fb_valid and frame_err SHALL be registered and high for exactly one uart_clk cycle; data_valid and frame_err SHALL never be high together.
REQ-025 The fields player_ready, target_reached and item_code SHALL update only on fb_valid and SHALL hold between feedback bytes; bytes with other tags (e.g. 2'b01 game-state echo) SHALL assert data_valid but not fb_valid.
REQ-026 A new start bit detected in IDLE on the cycle immediately after a stop-bit sample SHALL be accepted (back-to-back frames, no gap needed).
REQ-027 Latency from the first rx_s low cycle to the data_valid pulse SHALL be OVERSAMPLE/2 + 9*OVERSAMPLE + 1 uart_clk cycles.

Reset
REQ-028 When rst is high at a uart_clk edge, the module SHALL set state to IDLE, counters to 0, synchronizer flops to 1, data to 8'h00, all pulses to 0, player_ready and target_reached to 0, and item_code to 4'h0.
REQ-029 When rst is asserted mid-frame, the module SHALL discard the partial byte and SHALL emit no pulse; after release it SHALL wait for a fresh falling edge.

Verification
REQ-030 The bench SHALL send byte 8'hA4 (OVERSAMPLE=16) and check data=8'hA4, data_valid high one cycle, fb_valid high, item_code=4'hA, target_reached=0, player_ready=1.
REQ-031 The bench SHALL send 8'h05 and check data_valid=1, fb_valid=0, data=8'h05, and feedback fields unchanged from the previous test.
REQ-032 The bench SHALL drive an rx low pulse of 4 cycles and check a return to IDLE with no data_valid and no frame_err.
REQ-033 The bench SHALL send a frame with stop bit 0 followed by line low for 40 bit times, and check exactly one frame_err, data unchanged, and the next good byte 8'h3C received.
REQ-034 The bench SHALL send back-to-back 8'h10 and 8'hF8 without idle, and check two data_valid pulses 160 cycles apart with the correct values.
REQ-035 The bench SHALL assert rst during DATA bit 4 of 8'hFF, and check no pulse, all outputs at reset values, and the following 8'h2C decoded correctly.
